fetch_stage: RTL

Instruction-fetch stage of the ARM pipeline, directly upstream of the decode stage. It holds the program counter, reads a word-addressed instruction memory, and drives the IF/ID pipeline register that feeds decode's `instruction_in` and `pc_plus_four_in`. It handles hazard freeze, SRAM-stall freeze, branch redirect with flush, and a testbench/loader port for filling instruction memory.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Holds the program counter and reads a word-addressed
// instruction memory with an asynchronous read port. Loads the IF/ID pipeline
// register that feeds the decode stage. Supports hazard freeze, SRAM-stall
// freeze, taken-branch redirect with a one-slot flush, and a write port for
// loading the memory. Memory contents survive reset.
//
// Ports
//   clk                 : single clock, rising edge
//   rst                 : asynchronous reset, active low
//   hazard_freeze_in    : hold PC and IF/ID (hazard unit)
//   sram_freeze_in      : hold everything; overrides branch and hazard freeze
//   branch_taken_in     : branch resolved taken in EXE
//   branch_address_in   : branch target byte address
//   prog_we_in          : instruction-memory write enable
//   prog_addr_in        : instruction-memory word address to write
//   prog_data_in        : instruction word to write
//   pc_out              : current fetch address (registered)
//   instruction_out     : IF/ID instruction
//   pc_plus_four_out    : IF/ID PC+4
//   valid_out           : IF/ID holds a real fetched instruction
//   fetch_count_out     : number of instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned IMEM_ADDR_W = 8,
    parameter logic [31:0] NOP_INSTR   = 32'hE1A0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hazard_freeze_in,
    input  logic                   sram_freeze_in,
    input  logic                   branch_taken_in,
    input  logic [31:0]            branch_address_in,
    input  logic                   prog_we_in,
    input  logic [IMEM_ADDR_W-1:0] prog_addr_in,
    input  logic [31:0]            prog_data_in,
    output logic [31:0]            pc_out,
    output logic [31:0]            instruction_out,
    output logic [31:0]            pc_plus_four_out,
    output logic                   valid_out,
    output logic [31:0]            fetch_count_out
);

    localparam int unsigned DEPTH = 1 << IMEM_ADDR_W;

    // Instruction storage: no reset, so a reset does not wipe a loaded program.
    logic [31:0] imem_q [DEPTH];

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_inc_s;
    logic [31:0] fetch_word_s;

    // Byte offset bits and bits above the array are dropped, so the fetch
    // address wraps modulo the memory depth.
    assign pc_inc_s     = pc_q + 32'd4;
    assign fetch_word_s = imem_q[pc_q[IMEM_ADDR_W+1:2]];

    // Next-state selection in priority order: SRAM freeze, branch, hazard, fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (sram_freeze_in) begin
            // EXE is frozen as well, so a pending branch is presented again.
            pc_d    = pc_q;
            count_d = count_q;
        end else if (branch_taken_in) begin
            // The branch beats the hazard freeze: the word stalled in ID is on
            // the wrong path and must be squashed.
            pc_d    = branch_address_in;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (hazard_freeze_in) begin
            pc_d    = pc_q;
            count_d = count_q;
        end else begin
            pc_d    = pc_inc_s;
            instr_d = fetch_word_s;
            pc4_d   = pc_inc_s;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    // PC, IF/ID register and fetch counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= 32'd0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Program-port write; the IF/ID register sees the old word on a same-edge
    // read, the new word is fetched from the next cycle onward.
    always_ff @(posedge clk) begin
        if (prog_we_in) begin
            imem_q[prog_addr_in] <= prog_data_in;
        end
    end

    assign pc_out           = pc_q;
    assign instruction_out  = instr_q;
    assign pc_plus_four_out = pc4_q;
    assign valid_out        = valid_q;
    assign fetch_count_out  = count_q;

endmodule
